spi_flash_read_seq: RTL and testbench
=====================================

// Module: spi_flash_read_seq
// PURPOSE
//  Wishbone master that sequences the 8-bit MC68HC11-style SPI master core to run serial-flash READ commands.
//  Takes one request (24-bit address, byte count) and configures the core, asserts slave select, and shifts out opcode + address.
//  Returns the read bytes on a valid/ready stream, then deselects.
//  Sits between the boot/XIP fetch logic and the SPI core's Wishbone slave port.
// PARAMETERS
//  CS_INDEX   0      slave-select bit driven high in SS register (0..7)
//  SPCR_VAL   8'h50  value written to SPCR (SPE=1, MSTR forced by core, mode 0, div 2)
//  SPER_VAL   8'h00  value written to SPER (icnt=0, spre=0)
//  POLL_MAX   1023   SPSR polls per byte before timeout error (10-bit counter)
// PORTS
//  clk_i      in   1   clock
//  rst_i      in   1   reset, synchronous, active-high
//  req_i      in   1   start request; sampled only when busy_o=0
//  addr_i     in   24  flash byte address, captured on accept
//  len_i      in   8   data bytes minus one (0 -> 1 byte, 255 -> 256 bytes)
//  busy_o     out  1   high from accept cycle until done_o
//  done_o     out  1   one-cycle pulse at end of command
//  err_o      out  1   qualifies done_o: poll timeout occurred
//  rdata_o    out  8   read byte
//  rvalid_o   out  1   rdata_o valid; held until rready_i
//  rready_i   in   1   consumer ready
//  m_cyc_o    out  1   Wishbone cycle
//  m_stb_o    out  1   Wishbone strobe (equal to m_cyc_o)
//  m_we_o     out  1   Wishbone write enable
//  m_adr_o    out  3   core register: 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER, 4 SS
//  m_dat_o    out  8   write data
//  m_dat_i    in   8   read data, valid with m_ack_i
//  m_ack_i    in   1   core acknowledge
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; any bus cycle dropped immediately; no SS deselect write issued (the core is reset on the same reset).
//  Bus access: drive cyc/stb/we/adr/dat until m_ack_i=1; drop cyc/stb the next cycle.
//   At least one idle cycle between accesses (core re-acks held strobes).
//  Accept: IDLE & req_i -> capture addr_i, len_i; busy_o=1 next cycle; req_i ignored while busy.
//  States: IDLE -> CFG_SPCR (wr 0=SPCR_VAL) -> CFG_SPER (wr 3=SPER_VAL) -> SEL (wr 4=1<<CS_INDEX)
//   -> TX (wr 2=byte) -> POLL (rd 1) -> RX (rd 2) -> [OUT] -> TX.. -> DESEL (wr 4=0) -> DONE -> IDLE.
//  Header bytes: 8'h03, addr[23:16], addr[15:8], addr[7:0]. Their RX bytes are read and discarded.
//  Data phase: TX writes 8'h00; RX byte goes to OUT.
//   OUT: rvalid_o=1, rdata_o=byte; leave on rvalid_o&rready_i. No new TX while rvalid_o=1.
//  POLL: repeat SPSR reads until bit0 (rfempty)=0. Each poll increments a 10-bit counter, cleared on entering TX.
//   Counter reaching POLL_MAX -> latch err, go to DESEL (no further bytes).
//  Byte counter: 9-bit, loaded len_i+1 at accept; decremented per data RX; DESEL when it reaches 0 after OUT handshake.
//  DONE: done_o=1 for one cycle, err_o=latched err (0 otherwise), busy_o=0 the same cycle; IDLE next.
//  One byte in flight: core FIFOs never exceed depth 1; SPSR wcol is never set.
//  SPCR/SPER rewritten every command (core may have been reset or reprogrammed by software).
// CONFIGURATION
//  SPI_FAST_READ_EN defined: opcode 8'h0B plus one dummy 8'h00 after addr (5 discarded header bytes).
//  Undefined: opcode 8'h03, 4 header bytes. Everything else identical.
// TESTING
//  addr=24'h012345, len=0, flash model returns 8'hA5 -> MOSI 03 01 23 45 00; one rvalid A5; done_o=1, err_o=0; SS high then 0.
//  len=255, rready_i tied 1 -> exactly 256 rvalid beats in order; busy_o low only after the DESEL write ack.
//  rready_i low 50 cycles on byte 2 of 4 -> rvalid_o/rdata_o held stable; no SPDR write until accepted.
//  SPE forced 0 externally (rfempty stuck 1) -> after 1023 polls: DESEL write, done_o=1 with err_o=1, zero rvalid.
//  rst_i asserted during POLL -> next cycle m_cyc_o=0, busy_o=0, rvalid_o=0; a new request then completes normally.
//  SPI_FAST_READ_EN defined, addr=24'hFFFFFF, len=1 -> MOSI 0B FF FF FF 00 00 00; first 5 RX bytes discarded; 2 beats.

Source files
------------

// File: rtl/spi_flash_read_seq.sv
// Wishbone master that runs serial-flash READ commands through an 8-bit SPI master core.
// Optional SPI_FAST_READ_EN selects opcode 0x0B with one dummy byte after the address.
module spi_flash_read_seq #(
    parameter int unsigned CS_INDEX = 0,
    parameter logic [7:0]  SPCR_VAL = 8'h50,
    parameter logic [7:0]  SPER_VAL = 8'h00,
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    input  logic [7:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [2:0]  m_adr_o,
    output logic [7:0]  m_dat_o,
    input  logic [7:0]  m_dat_i,
    input  logic        m_ack_i
);

    localparam logic [2:0] ADR_SPCR = 3'd0;
    localparam logic [2:0] ADR_SPSR = 3'd1;
    localparam logic [2:0] ADR_SPDR = 3'd2;
    localparam logic [2:0] ADR_SPER = 3'd3;
    localparam logic [2:0] ADR_SS   = 3'd4;
    localparam logic [7:0] SS_VAL   = 8'(1 << CS_INDEX);
    localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);
`ifdef SPI_FAST_READ_EN
    localparam int unsigned HDR_N  = 5;
    localparam logic [7:0]  OPCODE = 8'h0B;
`else
    localparam int unsigned HDR_N  = 4;
    localparam logic [7:0]  OPCODE = 8'h03;
`endif
    localparam logic [2:0] HDR_DONE = 3'(HDR_N);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_SPCR, S_CFG_SPER, S_SEL, S_TX,
        S_POLL, S_RX, S_OUT, S_DESEL, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [2:0]  hdr_q, hdr_d;
    logic [9:0]  poll_q, poll_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d, done_q, done_d, err_out_q, err_out_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [7:0]  tx_byte;

    // Header byte sequence; past the header (and for the dummy byte) the core is clocked with zeros.
    always_comb begin
        tx_byte = 8'h00;
        case (hdr_q)
            3'd0:    tx_byte = OPCODE;
            3'd1:    tx_byte = addr_q[23:16];
            3'd2:    tx_byte = addr_q[15:8];
            3'd3:    tx_byte = addr_q[7:0];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            poll_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            poll_q    <= poll_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Each access state raises cyc on its first cycle (cyc low = idle gap) and advances on ack.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        poll_d    = poll_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_out_d = 1'b0;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    cnt_d   = 9'(len_i) + 9'd1;
                    hdr_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CFG_SPCR;
                end
            end
            S_CFG_SPCR: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPCR; dat_d = SPCR_VAL;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0; state_d = S_CFG_SPER;
                end
            end
            S_CFG_SPER: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPER; dat_d = SPER_VAL;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0; state_d = S_SEL;
                end
            end
            S_SEL: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SS; dat_d = SS_VAL;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0; state_d = S_TX;
                end
            end
            S_TX: begin
                poll_d = '0;
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SPDR; dat_d = tx_byte;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0; state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPSR;
                end else if (m_ack_i) begin
                    cyc_d  = 1'b0;
                    poll_d = poll_q + 10'd1;
                    if (!m_dat_i[0]) begin
                        state_d = S_RX;
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DESEL;
                    end
                end
            end
            S_RX: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_SPDR;
                end else if (m_ack_i) begin
                    cyc_d = 1'b0;
                    if (hdr_q != HDR_DONE) begin
                        hdr_d   = hdr_q + 3'd1;
                        state_d = S_TX;
                    end else begin
                        rdata_d  = m_dat_i;
                        rvalid_d = 1'b1;
                        cnt_d    = cnt_q - 9'd1;
                        state_d  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (rvalid_q && rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = (cnt_q == 9'd0) ? S_DESEL : S_TX;
                end
            end
            S_DESEL: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_SS; dat_d = 8'h00;
                end else if (m_ack_i) begin
                    cyc_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_out_d = err_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_out_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign m_cyc_o  = cyc_q;
    assign m_stb_o  = cyc_q;
    assign m_we_o   = we_q;
    assign m_adr_o  = adr_q;
    assign m_dat_o  = dat_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Randomized bench for spi_flash_read_seq: SPI core + flash responder on Wishbone, command-level reference model.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;

    localparam int unsigned POLL_MAX = 1023;
    localparam logic [7:0]  SS_VAL   = 8'h01;
`ifdef SPI_FAST_READ_EN
    localparam int HDR_N = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int HDR_N = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, rready_i, m_ack_i;
    logic [23:0] addr_i;
    logic [7:0]  len_i, m_dat_i;
    logic        busy_o, done_o, err_o, rvalid_o, m_cyc_o, m_stb_o, m_we_o;
    logic [7:0]  rdata_o, m_dat_o;
    logic [2:0]  m_adr_o;

    always #5 clk_i = ~clk_i;

    spi_flash_read_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC2;
    endfunction

    // Responder / reference state
    logic [7:0]  mosi_q[$];
    logic [7:0]  ss_log[$];
    logic [7:0]  beats[$];
    logic [7:0]  spcr_w, sper_w, rx_byte;
    logic [23:0] cur_addr;
    logic        rx_full = 1'b0, stuck = 1'b0, rand_timing = 1'b0, stall_mode = 1'b0;
    int          rx_delay = -1, wait_left = -1, byte_idx = 0, poll_cnt = 0;
    int          done_cnt = 0, stall_cnt = 0;
    logic        last_err;

    task automatic bus_effect();
        case (m_adr_o)
            3'd0: if (m_we_o) spcr_w = m_dat_o;
            3'd3: if (m_we_o) sper_w = m_dat_o;
            3'd4: if (m_we_o) begin
                ss_log.push_back(m_dat_o);
                if (m_dat_o != 8'h00) begin
                    byte_idx = 0; rx_full = 1'b0; rx_delay = -1;
                end
            end
            3'd2: if (m_we_o) begin
                check_val("no_tx_while_rvalid", 32'(rvalid_o), 32'd0);
                check_val("fifo_depth1", 32'({rx_full, rx_delay >= 0}), 32'd0);
                mosi_q.push_back(m_dat_o);
                if (!stuck) begin
                    rx_byte  = (byte_idx < HDR_N) ? 8'hC3
                             : flash_byte(24'(cur_addr + 24'(byte_idx - HDR_N)));
                    rx_delay = rand_timing ? int'($urandom_range(0, 4)) : 1;
                end
                byte_idx++;
            end else begin
                m_dat_i = rx_byte;
                rx_full = 1'b0;
            end
            3'd1: begin
                m_dat_i = {7'b0, ~rx_full};
                poll_cnt++;
            end
            default: ;
        endcase
    endtask

    // SPI core + flash responder
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = 8'h00;
        forever begin
            @(posedge clk_i); #1;
            if (rst_i) begin
                m_ack_i = 1'b0; wait_left = -1;
            end else begin
                if (rx_delay > 0) rx_delay--;
                else if (rx_delay == 0) begin rx_full = 1'b1; rx_delay = -1; end
                if (m_ack_i) m_ack_i = 1'b0;
                else if (m_cyc_o && m_stb_o) begin
                    if (wait_left < 0) wait_left = rand_timing ? int'($urandom_range(0, 2)) : 0;
                    if (wait_left > 0) wait_left--;
                    else begin
                        wait_left = -1;
                        m_ack_i   = 1'b1;
                        bus_effect();
                    end
                end
            end
        end
    end

    // Consumer
    initial begin
        rready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            if (stall_mode && beats.size() == 1 && rvalid_o && stall_cnt < 50) begin
                rready_i = 1'b0; stall_cnt++;
            end else if (rand_timing) rready_i = ($urandom_range(0, 3) != 0);
            else rready_i = 1'b1;
        end
    end

    // Stream / completion monitor
    logic       prev_v = 1'b0, prev_hs = 1'b0;
    logic [7:0] prev_d = 8'h00;
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) prev_v = 1'b0;
            else begin
                if (rvalid_o && prev_v && !prev_hs) check_val("rdata_hold", 32'(rdata_o), 32'(prev_d));
                if (rvalid_o && rready_i) begin
                    beats.push_back(rdata_o);
                    check_val("busy_during_beat", 32'(busy_o), 32'd1);
                end
                prev_v = rvalid_o; prev_hs = rvalid_o && rready_i; prev_d = rdata_o;
                if (done_o) begin
                    done_cnt++;
                    last_err = err_o;
                    check_val("busy_at_done", 32'(busy_o), 32'd0);
                    check_val("desel_before_done", 32'(ss_log.size() > 0 ? ss_log[$] : 8'hEE), 32'd0);
                end
            end
        end
    end

    task automatic start_cmd(input logic [23:0] a, input int len, input bit stk, input bit rt, input bit stall);
        mosi_q.delete(); ss_log.delete(); beats.delete();
        done_cnt = 0; poll_cnt = 0; stall_cnt = 0;
        stuck = stk; rand_timing = rt; stall_mode = stall; cur_addr = a;
        spcr_w = 8'hEE; sper_w = 8'hEE;
        @(posedge clk_i); #1;
        req_i = 1'b1; addr_i = a; len_i = 8'(len);
        @(posedge clk_i); #1;
        req_i = 1'b1; addr_i = 24'($urandom); len_i = 8'($urandom);
        check_val("busy_after_accept", 32'(busy_o), 32'd1);
        @(posedge clk_i); #1;
        req_i = 1'b0;
    endtask

    task automatic run_cmd(input logic [23:0] a, input int len, input bit stk, input bit rt,
                           input bit stall, input bit exp_err);
        logic [7:0] exp_mosi[$];
        int cyc = 0;
        int nb;
        start_cmd(a, len, stk, rt, stall);
        while (done_cnt == 0 && cyc < 30000) begin @(posedge clk_i); cyc++; end
        repeat (3) @(posedge clk_i);
        #1;
        check_val("done_count", 32'(done_cnt), 32'd1);
        check_val("err", 32'(last_err), 32'(exp_err));
        check_val("spcr", 32'(spcr_w), 32'h50);
        check_val("sper", 32'(sper_w), 32'h00);
        check_val("ss_writes", 32'(ss_log.size()), 32'd2);
        if (ss_log.size() == 2) begin
            check_val("ss_sel", 32'(ss_log[0]), 32'(SS_VAL));
            check_val("ss_desel", 32'(ss_log[1]), 32'd0);
        end
        exp_mosi.push_back(OPC);
        if (!exp_err) begin
            exp_mosi.push_back(a[23:16]); exp_mosi.push_back(a[15:8]); exp_mosi.push_back(a[7:0]);
            if (HDR_N == 5) exp_mosi.push_back(8'h00);
            for (int k = 0; k <= len; k++) exp_mosi.push_back(8'h00);
        end
        check_val("mosi_len", 32'(mosi_q.size()), 32'(exp_mosi.size()));
        for (int k = 0; k < exp_mosi.size() && k < mosi_q.size(); k++)
            check_val($sformatf("mosi[%0d]", k), 32'(mosi_q[k]), 32'(exp_mosi[k]));
        nb = exp_err ? 0 : len + 1;
        check_val("beat_count", 32'(beats.size()), 32'(nb));
        for (int k = 0; k < nb && k < beats.size(); k++)
            check_val($sformatf("beat[%0d]", k), 32'(beats[k]), 32'(flash_byte(24'(a + 24'(k)))));
        if (exp_err) check_val("poll_count", 32'(poll_cnt), 32'(POLL_MAX));
    endtask

    initial begin
        int cyc;
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; len_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_val("rst_rdata", 32'(rdata_o), 32'd0);
        check_val("rst_cyc", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'd0);
        check_val("rst_bus", 32'({m_adr_o, m_dat_o}), 32'd0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        run_cmd(24'h012345, 0, 0, 0, 0, 0);
        if (beats.size() > 0) check_val("first_byte_a5", 32'(beats[0]), 32'hA5);
        run_cmd(24'h100000, 255, 0, 0, 0, 0);
        run_cmd(24'h00ABCD, 3, 0, 0, 1, 0);
        check_val("stall_cycles", 32'(stall_cnt), 32'd50);
        run_cmd(24'h222222, 3, 1, 0, 0, 1);

        // Reset in the middle of SPSR polling
        start_cmd(24'h333333, 7, 1, 0, 0);
        cyc = 0;
        while (poll_cnt < 5 && cyc < 2000) begin @(posedge clk_i); cyc++; end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check_val("midrst_cyc", 32'(m_cyc_o), 32'd0);
        check_val("midrst_busy", 32'(busy_o), 32'd0);
        check_val("midrst_rvalid", 32'(rvalid_o), 32'd0);
        rst_i = 1'b0;
        rx_full = 1'b0; rx_delay = -1;
        repeat (2) @(posedge clk_i);
        run_cmd(24'h444444, 2, 0, 1, 0, 0);

        run_cmd(24'hFFFFFF, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_cmd(24'($urandom), int'($urandom_range(0, 15)), 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
